// File: rtl/wb_mailbox_bridge_if.sv
// Bus bundle for wb_mailbox_bridge: mgmt and cpu Wishbone slave ports
// plus both interrupt lines. slave = bridge side, master = bus side.
interface wb_mailbox_bridge_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;
   logic        cpu_wb_cyc_i;
   logic        cpu_wb_stb_i;
   logic        cpu_wb_we_i;
   logic [3:0]  cpu_wb_sel_i;
   logic [31:0] cpu_wb_adr_i;
   logic [31:0] cpu_wb_dat_i;
   logic        cpu_wb_ack_o;
   logic [31:0] cpu_wb_dat_o;
   logic        mgmt_irq_o;
   logic        cpu_irq_o;

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i,
      input  wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o,
      input  cpu_wb_cyc_i, cpu_wb_stb_i, cpu_wb_we_i,
      input  cpu_wb_sel_i, cpu_wb_adr_i, cpu_wb_dat_i,
      output cpu_wb_ack_o, cpu_wb_dat_o,
      output mgmt_irq_o, cpu_irq_o
   );

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i,
      output wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o,
      output cpu_wb_cyc_i, cpu_wb_stb_i, cpu_wb_we_i,
      output cpu_wb_sel_i, cpu_wb_adr_i, cpu_wb_dat_i,
      input  cpu_wb_ack_o, cpu_wb_dat_o,
      input  mgmt_irq_o, cpu_irq_o
   );
endinterface

// File: rtl/wb_mailbox_bridge.sv
// Bidirectional Wishbone mailbox: mgmt (Caravel) <-> cpu (NEORV32).
// Ports: wb_clk_i, wb_rst_i (async, high), bus (slave modport).

module wb_mailbox_fifo #(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int LW    = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_i,
   input  logic [31:0]   data_i,
   input  logic          pop_i,
   output logic [31:0]   data_o,
   output logic          full_o,
   output logic          empty_o,
   output logic [LW-1:0] level_o,
   output logic          ovf_o,
   output logic          unf_o
);
   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
   logic [LW-1:0] lvl_q, lvl_d;
   logic          push_ok, pop_ok;

   assign full_o  = (lvl_q == LW'(DEPTH));
   assign empty_o = (lvl_q == '0);
   assign level_o = lvl_q;
   // Decisions use start-of-cycle level: a full FIFO drops a push
   // even when the other side pops in the same cycle.
   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;
   assign ovf_o   = push_i & full_o;
   assign unf_o   = pop_i & empty_o;
   assign data_o  = empty_o ? '0 : mem_q[rp_q];

   always_comb begin
      wp_d  = wp_q + AW'(push_ok);
      rp_d  = rp_q + AW'(pop_ok);
      lvl_d = lvl_q + LW'(push_ok) - LW'(pop_ok);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wp_q  <= '0;
         rp_q  <= '0;
         lvl_q <= '0;
      end else begin
         wp_q  <= wp_d;
         rp_q  <= rp_d;
         lvl_q <= lvl_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wp_q] <= data_i;
   end
endmodule

module wb_mailbox_bridge #(
   parameter int          DEPTH     = 4,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input logic                 wb_clk_i,
   input logic                 wb_rst_i,
   wb_mailbox_bridge_if.slave  bus
);
   localparam int LW = $clog2(DEPTH) + 1;

   function automatic logic [31:0] status(
      input logic rxe, rxf, txe, txf, ovf, unf,
      input logic [LW-1:0] rxl, txl
   );
      logic [31:0] s;
      s        = '0;
      s[0]     = rxe;
      s[1]     = rxf;
      s[2]     = txe;
      s[3]     = txf;
      s[4]     = ovf;
      s[5]     = unf;
      s[12:8]  = 5'(rxl);
      s[20:16] = 5'(txl);
      return s;
   endfunction

   // Latched request per port; the access completes in the ack cycle.
   logic        m_ack_q, m_ack_d, m_we_q;
   logic [1:0]  m_off_q;
   logic [31:0] m_wd_q, m_rdata;
   logic        c_ack_q, c_ack_d, c_we_q;
   logic [1:0]  c_off_q;
   logic [31:0] c_wd_q, c_rdata;

   logic m_ovf_q, m_ovf_d, m_unf_q, m_unf_d, m_en_q, m_en_d;
   logic c_ovf_q, c_ovf_d, c_unf_q, c_unf_d, c_en_q, c_en_d;
   logic m_irq_q, m_irq_d, c_irq_q, c_irq_d;

   logic m_hit, m_wr, m_rd, c_wr, c_rd;
   logic m_push, m_pop, c_push, c_pop, m_sclr, c_sclr;

   // m2c: written by mgmt, read by cpu. c2m: the reverse.
   logic [31:0]   m2c_data, c2m_data;
   logic          m2c_full, m2c_empty, m2c_ovf, m2c_unf;
   logic          c2m_full, c2m_empty, c2m_ovf, c2m_unf;
   logic [LW-1:0] m2c_lvl, c2m_lvl;

   logic unused_ok;
   assign unused_ok = ^{bus.wbs_sel_i, bus.cpu_wb_sel_i,
                        bus.wbs_adr_i[1:0], bus.cpu_wb_adr_i[31:4],
                        bus.cpu_wb_adr_i[1:0]};

   assign m_hit   = (bus.wbs_adr_i[31:4] == BASE_ADDR[31:4]);
   assign m_ack_d = bus.wbs_cyc_i & bus.wbs_stb_i & ~m_ack_q & m_hit;
   assign c_ack_d = bus.cpu_wb_cyc_i & bus.cpu_wb_stb_i & ~c_ack_q;

   assign m_wr   = m_ack_q & m_we_q;
   assign m_rd   = m_ack_q & ~m_we_q;
   assign c_wr   = c_ack_q & c_we_q;
   assign c_rd   = c_ack_q & ~c_we_q;
   assign m_push = m_wr & (m_off_q == 2'd0);
   assign m_pop  = m_rd & (m_off_q == 2'd0);
   assign c_push = c_wr & (c_off_q == 2'd0);
   assign c_pop  = c_rd & (c_off_q == 2'd0);
   assign m_sclr = m_wr & (m_off_q == 2'd1);
   assign c_sclr = c_wr & (c_off_q == 2'd1);

   wb_mailbox_fifo #(.DEPTH(DEPTH)) u_m2c (
      .clk_i   (wb_clk_i),
      .rst_i   (wb_rst_i),
      .push_i  (m_push),
      .data_i  (m_wd_q),
      .pop_i   (c_pop),
      .data_o  (m2c_data),
      .full_o  (m2c_full),
      .empty_o (m2c_empty),
      .level_o (m2c_lvl),
      .ovf_o   (m2c_ovf),
      .unf_o   (m2c_unf)
   );

   wb_mailbox_fifo #(.DEPTH(DEPTH)) u_c2m (
      .clk_i   (wb_clk_i),
      .rst_i   (wb_rst_i),
      .push_i  (c_push),
      .data_i  (c_wd_q),
      .pop_i   (m_pop),
      .data_o  (c2m_data),
      .full_o  (c2m_full),
      .empty_o (c2m_empty),
      .level_o (c2m_lvl),
      .ovf_o   (c2m_ovf),
      .unf_o   (c2m_unf)
   );

   // Sticky flags: a same-cycle event wins over a clear.
   always_comb begin
      m_ovf_d = m2c_ovf | (m_ovf_q & ~(m_sclr & m_wd_q[4]));
      m_unf_d = c2m_unf | (m_unf_q & ~(m_sclr & m_wd_q[5]));
      c_ovf_d = c2m_ovf | (c_ovf_q & ~(c_sclr & c_wd_q[4]));
      c_unf_d = m2c_unf | (c_unf_q & ~(c_sclr & c_wd_q[5]));
      m_en_d  = m_en_q;
      c_en_d  = c_en_q;
      if (m_wr && m_off_q == 2'd2) m_en_d = m_wd_q[0];
      if (c_wr && c_off_q == 2'd2) c_en_d = c_wd_q[0];
      m_irq_d = m_en_q & ~c2m_empty;
      c_irq_d = c_en_q & ~m2c_empty;
   end

   always_comb begin
      m_rdata = '0;
      unique case (m_off_q)
         2'd0:    m_rdata = c2m_data;
         2'd1:    m_rdata = status(c2m_empty, c2m_full,
                                   m2c_empty, m2c_full,
                                   m_ovf_q, m_unf_q,
                                   c2m_lvl, m2c_lvl);
         2'd2:    m_rdata = {31'b0, m_en_q};
         default: m_rdata = '0;
      endcase
   end

   always_comb begin
      c_rdata = '0;
      unique case (c_off_q)
         2'd0:    c_rdata = m2c_data;
         2'd1:    c_rdata = status(m2c_empty, m2c_full,
                                   c2m_empty, c2m_full,
                                   c_ovf_q, c_unf_q,
                                   m2c_lvl, c2m_lvl);
         2'd2:    c_rdata = {31'b0, c_en_q};
         default: c_rdata = '0;
      endcase
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         m_ack_q <= 1'b0;
         m_we_q  <= 1'b0;
         m_off_q <= '0;
         m_wd_q  <= '0;
         c_ack_q <= 1'b0;
         c_we_q  <= 1'b0;
         c_off_q <= '0;
         c_wd_q  <= '0;
         m_ovf_q <= 1'b0;
         m_unf_q <= 1'b0;
         m_en_q  <= 1'b0;
         c_ovf_q <= 1'b0;
         c_unf_q <= 1'b0;
         c_en_q  <= 1'b0;
         m_irq_q <= 1'b0;
         c_irq_q <= 1'b0;
      end else begin
         m_ack_q <= m_ack_d;
         c_ack_q <= c_ack_d;
         if (m_ack_d) begin
            m_we_q  <= bus.wbs_we_i;
            m_off_q <= bus.wbs_adr_i[3:2];
            m_wd_q  <= bus.wbs_dat_i;
         end
         if (c_ack_d) begin
            c_we_q  <= bus.cpu_wb_we_i;
            c_off_q <= bus.cpu_wb_adr_i[3:2];
            c_wd_q  <= bus.cpu_wb_dat_i;
         end
         m_ovf_q <= m_ovf_d;
         m_unf_q <= m_unf_d;
         m_en_q  <= m_en_d;
         c_ovf_q <= c_ovf_d;
         c_unf_q <= c_unf_d;
         c_en_q  <= c_en_d;
         m_irq_q <= m_irq_d;
         c_irq_q <= c_irq_d;
      end
   end

   assign bus.wbs_ack_o    = m_ack_q;
   assign bus.cpu_wb_ack_o = c_ack_q;
   assign bus.wbs_dat_o    = m_rd ? m_rdata : '0;
   assign bus.cpu_wb_dat_o = c_rd ? c_rdata : '0;
   assign bus.mgmt_irq_o   = m_irq_q;
   assign bus.cpu_irq_o    = c_irq_q;
endmodule

// File: tb/tb_wb_mailbox_bridge.sv
// Directed scoreboard bench for wb_mailbox_bridge (DEPTH=4).
// Drives both Wishbone ports through the interface instance.
module tb_wb_mailbox_bridge;
   localparam logic [31:0] MB = 32'h3000_0000;
   localparam logic [31:0] CB = 32'hF000_0000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   wb_mailbox_bridge_if bus ();

   wb_mailbox_bridge #(.DEPTH(4), .BASE_ADDR(MB)) dut (
      .wb_clk_i (clk),
      .wb_rst_i (rst),
      .bus      (bus)
   );

   int total  = 0;
   int passed = 0;
   int fails  = 0;
   logic [31:0] m2c_q[$];
   logic [31:0] c2m_q[$];
   logic [31:0] r1, r2, ex;
   int acks;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic m_acc(input logic we, input logic [31:0] adr,
                        input logic [31:0] wd, output logic [31:0] rd);
      logic got;
      got = 1'b0;
      rd  = '0;
      @(posedge clk);
      #1;
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = we;
      bus.wbs_adr_i = adr;
      bus.wbs_dat_i = wd;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.wbs_ack_o) begin
            got = 1'b1;
            rd  = bus.wbs_dat_o;
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      chk("mgmt_ack_seen", 32'(got), 32'd1);
   endtask

   task automatic c_acc(input logic we, input logic [31:0] adr,
                        input logic [31:0] wd, output logic [31:0] rd);
      logic got;
      got = 1'b0;
      rd  = '0;
      @(posedge clk);
      #1;
      bus.cpu_wb_cyc_i = 1'b1;
      bus.cpu_wb_stb_i = 1'b1;
      bus.cpu_wb_we_i  = we;
      bus.cpu_wb_adr_i = adr;
      bus.cpu_wb_dat_i = wd;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.cpu_wb_ack_o) begin
            got = 1'b1;
            rd  = bus.cpu_wb_dat_o;
            break;
         end
      end
      @(posedge clk);
      #1;
      bus.cpu_wb_cyc_i = 1'b0;
      bus.cpu_wb_stb_i = 1'b0;
      bus.cpu_wb_we_i  = 1'b0;
      chk("cpu_ack_seen", 32'(got), 32'd1);
   endtask

   task automatic m_push(input logic [31:0] v);
      logic [31:0] d;
      if (m2c_q.size() < 4) m2c_q.push_back(v);
      m_acc(1'b1, MB, v, d);
   endtask

   task automatic c_push(input logic [31:0] v);
      logic [31:0] d;
      if (c2m_q.size() < 4) c2m_q.push_back(v);
      c_acc(1'b1, CB, v, d);
   endtask

   task automatic c_pop(input string tag);
      logic [31:0] d, e;
      e = (m2c_q.size() > 0) ? m2c_q.pop_front() : 32'h0;
      c_acc(1'b0, CB, 32'h0, d);
      chk(tag, d, e);
   endtask

   task automatic m_pop(input string tag);
      logic [31:0] d, e;
      e = (c2m_q.size() > 0) ? c2m_q.pop_front() : 32'h0;
      m_acc(1'b0, MB, 32'h0, d);
      chk(tag, d, e);
   endtask

   task automatic m_stat(input string tag, input logic [31:0] e);
      logic [31:0] d;
      m_acc(1'b0, MB + 32'h4, 32'h0, d);
      chk(tag, d, e);
   endtask

   task automatic c_stat(input string tag, input logic [31:0] e);
      logic [31:0] d;
      c_acc(1'b0, CB + 32'h4, 32'h0, d);
      chk(tag, d, e);
   endtask

   initial begin
      bus.wbs_cyc_i    = 1'b0;
      bus.wbs_stb_i    = 1'b0;
      bus.wbs_we_i     = 1'b0;
      bus.wbs_sel_i    = 4'hF;
      bus.wbs_adr_i    = '0;
      bus.wbs_dat_i    = '0;
      bus.cpu_wb_cyc_i = 1'b0;
      bus.cpu_wb_stb_i = 1'b0;
      bus.cpu_wb_we_i  = 1'b0;
      bus.cpu_wb_sel_i = 4'hF;
      bus.cpu_wb_adr_i = '0;
      bus.cpu_wb_dat_i = '0;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_mack", 32'(bus.wbs_ack_o), 32'd0);
      chk("rst_cack", 32'(bus.cpu_wb_ack_o), 32'd0);
      chk("rst_mdat", bus.wbs_dat_o, 32'd0);
      chk("rst_cdat", bus.cpu_wb_dat_o, 32'd0);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_mirq", 32'(bus.mgmt_irq_o), 32'd0);
      chk("rst_cirq", 32'(bus.cpu_irq_o), 32'd0);
      m_stat("m_stat_rst", 32'h0000_0005);
      c_stat("c_stat_rst", 32'h0000_0005);

      // mgmt -> cpu single word
      m_push(32'hDEAD_BEEF);
      c_stat("c_stat_lvl1", 32'h0000_0104);
      c_pop("c_pop_beef");
      c_stat("c_stat_empty", 32'h0000_0005);

      // cpu overflow, mgmt drain, mgmt underflow, clears
      for (int i = 0; i < 5; i++) c_push(32'hA000_0000 + 32'(i));
      c_stat("c_stat_ovf", 32'h0004_0019);
      m_stat("m_stat_full", 32'h0000_0406);
      for (int i = 0; i < 4; i++) m_pop("m_pop_order");
      m_pop("m_pop_empty");
      m_stat("m_stat_unf", 32'h0000_0025);
      m_acc(1'b1, MB + 32'h4, 32'h20, r1);
      m_stat("m_stat_unfclr", 32'h0000_0005);
      c_acc(1'b1, CB + 32'h4, 32'h10, r1);
      c_stat("c_stat_ovfclr", 32'h0000_0005);

      // cpu irq timing
      c_acc(1'b1, CB + 32'h8, 32'hFFFF_FFFF, r1);
      c_acc(1'b0, CB + 32'h8, 32'h0, r1);
      chk("c_irqen_rd", r1, 32'h1);
      m_push(32'h1234_5678);
      chk("irq_ack1", 32'(bus.cpu_irq_o), 32'd0);
      @(negedge clk);
      chk("irq_ack1_5", 32'(bus.cpu_irq_o), 32'd0);
      @(negedge clk);
      chk("irq_ack2_5", 32'(bus.cpu_irq_o), 32'd1);
      c_pop("c_pop_irq");
      @(negedge clk);
      @(negedge clk);
      chk("irq_fall", 32'(bus.cpu_irq_o), 32'd0);
      c_acc(1'b1, CB + 32'h8, 32'h0, r1);

      // Full FIFO: same-cycle push and pop
      for (int i = 0; i < 4; i++) m_push(32'hB000_0000 + 32'(i));
      c_stat("c_stat_full", 32'h0000_0406);
      ex = m2c_q.pop_front();
      fork
         m_acc(1'b1, MB, 32'h5555_AAAA, r1);
         c_acc(1'b0, CB, 32'h0, r2);
      join
      chk("sim_pop", r2, ex);
      c_stat("c_stat_sim", 32'h0000_0304);
      m_stat("m_stat_sim", 32'h0003_0011);
      for (int i = 0; i < 3; i++) c_pop("c_pop_drain");

      // Out-of-window mgmt access
      @(posedge clk);
      #1;
      bus.wbs_cyc_i = 1'b1;
      bus.wbs_stb_i = 1'b1;
      bus.wbs_we_i  = 1'b1;
      bus.wbs_adr_i = 32'h3000_0010;
      bus.wbs_dat_i = 32'hCAFE_0001;
      acks = 0;
      repeat (10) begin
         @(negedge clk);
         if (bus.wbs_ack_o) acks++;
      end
      bus.wbs_cyc_i = 1'b0;
      bus.wbs_stb_i = 1'b0;
      bus.wbs_we_i  = 1'b0;
      chk("bad_adr_ack", 32'(acks), 32'd0);
      c_stat("c_stat_badadr", 32'h0000_0005);
      m_stat("m_stat_sticky", 32'h0000_0015);

      // Reset during a pending cpu ack
      m_push(32'h7777_7777);
      c_acc(1'b1, CB + 32'h8, 32'h1, r1);
      @(negedge clk);
      @(negedge clk);
      chk("pre_rst_irq", 32'(bus.cpu_irq_o), 32'd1);
      @(posedge clk);
      #1;
      bus.cpu_wb_cyc_i = 1'b1;
      bus.cpu_wb_stb_i = 1'b1;
      bus.cpu_wb_we_i  = 1'b1;
      bus.cpu_wb_adr_i = CB;
      bus.cpu_wb_dat_i = 32'h9999_9999;
      #2;
      rst  = 1'b1;
      acks = 0;
      repeat (4) begin
         @(negedge clk);
         if (bus.cpu_wb_ack_o) acks++;
      end
      rst = 1'b0;
      bus.cpu_wb_cyc_i = 1'b0;
      bus.cpu_wb_stb_i = 1'b0;
      bus.cpu_wb_we_i  = 1'b0;
      m2c_q.delete();
      c2m_q.delete();
      chk("rst_pend_ack", 32'(acks), 32'd0);
      @(negedge clk);
      chk("rst_pend_irq", 32'(bus.cpu_irq_o), 32'd0);
      m_stat("m_stat_rst2", 32'h0000_0005);
      c_stat("c_stat_rst2", 32'h0000_0005);
      c_acc(1'b0, CB + 32'h8, 32'h0, r1);
      chk("c_irqen_rst2", r1, 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
